// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: byte-addressed instruction RAM, PC sequencing with
// jump redirect / stall / halt freeze, the IF/ID instruction latch, and a
// streaming byte loader with a valid/ready handshake.
// Build macro IF_HALT_DETECT_EN: adds the HALTED state, entered once the
// all-ones HALT word has been latched; without it o_halted is tied low.
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [31:0]           RESET_PC   = 32'h0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = '0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic                  i_halt,
  input  logic                  i_jump,
  input  logic [31:0]           i_jump_address,
  input  logic                  i_load_start,
  input  logic                  i_load_valid,
  input  logic [7:0]            i_load_data,
  input  logic                  i_load_last,
  output logic                  o_load_ready,
  output logic                  o_load_done,
  output logic                  o_load_overflow,
  output logic [DATA_WIDTH-1:0] o_instruction,
  output logic [31:0]           o_pc,
  output logic [31:0]           o_pc_plus4,
  output logic                  o_valid,
  output logic                  o_halted
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef IF_HALT_DETECT_EN
  typedef enum logic [1:0] {RUN = 2'd0, LOAD = 2'd1, HALTED = 2'd2} state_t;
`else
  typedef enum logic [1:0] {RUN = 2'd0, LOAD = 2'd1} state_t;
`endif

  state_t                  state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [31:0]             pc_plus4_q, pc_plus4_d;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    overflow_q, overflow_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    mem_we;

  logic [7:0]              mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   fetch_base;
  logic [DATA_WIDTH-1:0]   fetch_word;

  // Redirect targets are forced word-aligned, so the low two bits never matter.
  logic unused_jump_lsbs;
  assign unused_jump_lsbs = ^i_jump_address[1:0];

  // Asynchronous big-endian word read at the word-aligned PC, wrapping in the RAM.
  always_comb begin
    fetch_base = {pc_q[ADDR_WIDTH-1:2], 2'b00};
    fetch_word = '0;
    for (int i = 0; i < BYTES; i++) begin
      fetch_word[DATA_WIDTH-1-8*i -: 8] = mem_q[fetch_base + ADDR_WIDTH'(i)];
    end
  end

`ifdef IF_HALT_DETECT_EN
  logic halt_seen;
  assign halt_seen = valid_q && (instr_q == {DATA_WIDTH{1'b1}});
`endif

  // Next-state and datapath update: FSM, PC sequencing, latch and loader pointer.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    ptr_d      = ptr_q;
    mem_we     = 1'b0;
    case (state_q)
      RUN: begin
        if (i_load_start) begin
          state_d    = LOAD;
          instr_d    = NOP_INSTR;
          valid_d    = 1'b0;
          ready_d    = 1'b1;
          ptr_d      = '0;
          overflow_d = 1'b0;
`ifdef IF_HALT_DETECT_EN
        end else if (halt_seen) begin
          // HALT word is already in the latch; PC sits at its address + 4.
          state_d = HALTED;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
`endif
        end else if (i_halt) begin
          // Full freeze: nothing moves.
          state_d = RUN;
        end else if (i_jump) begin
          // Redirect wins over stall and injects a single bubble.
          pc_d    = {i_jump_address[31:2], 2'b00};
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (i_stall) begin
          state_d = RUN;
        end else begin
          instr_d    = fetch_word;
          pc_plus4_d = pc_q + 32'd4;
          pc_d       = pc_q + 32'd4;
          valid_d    = 1'b1;
        end
      end
      LOAD: begin
        if (i_load_start) begin
          // Restart: rewind the pointer and forget any earlier wrap.
          ptr_d      = '0;
          overflow_d = 1'b0;
        end else if (i_load_valid && ready_q) begin
          mem_we = 1'b1;
          if (i_load_last) begin
            state_d = RUN;
            pc_d    = RESET_PC;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            ready_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == {ADDR_WIDTH{1'b1}}) overflow_d = 1'b1;
          end
        end
      end
`ifdef IF_HALT_DETECT_EN
      HALTED: begin
        if (i_load_start) begin
          state_d    = LOAD;
          instr_d    = NOP_INSTR;
          valid_d    = 1'b0;
          ready_d    = 1'b1;
          ptr_d      = '0;
          overflow_d = 1'b0;
        end
      end
`endif
      default: state_d = RUN;
    endcase
  end

  // Control and IF/ID state registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      ptr_q      <= ptr_d;
    end
  end

  // Instruction RAM write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_reset && mem_we) mem_q[ptr_q] <= i_load_data;
  end

  assign o_load_ready    = ready_q;
  assign o_load_done     = done_q;
  assign o_load_overflow = overflow_q;
  assign o_instruction   = instr_q;
  assign o_pc            = pc_q;
  assign o_pc_plus4      = pc_plus4_q;
  assign o_valid         = valid_q;
`ifdef IF_HALT_DETECT_EN
  assign o_halted        = (state_q == HALTED);
`else
  assign o_halted        = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a full-size instance (1 KiB RAM,
// non-zero NOP) and a 16-byte instance (pointer wrap) share all inputs.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_reset, i_stall, i_halt, i_jump;
  logic [31:0] i_jump_address;
  logic        i_load_start, i_load_valid, i_load_last;
  logic [7:0]  i_load_data;

  logic        b_ready, b_done, b_ovf, b_valid, b_halted;
  logic [31:0] b_instr, b_pc, b_pc4;
  logic        s_ready, s_done, s_ovf, s_valid, s_halted;
  logic [31:0] s_instr, s_pc, s_pc4;

  always #5 i_clk = ~i_clk;

  instruction_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RESET_PC(32'h0),
                           .NOP_INSTR(NOP)) u_big (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_halt(i_halt),
    .i_jump(i_jump), .i_jump_address(i_jump_address), .i_load_start(i_load_start),
    .i_load_valid(i_load_valid), .i_load_data(i_load_data), .i_load_last(i_load_last),
    .o_load_ready(b_ready), .o_load_done(b_done), .o_load_overflow(b_ovf),
    .o_instruction(b_instr), .o_pc(b_pc), .o_pc_plus4(b_pc4), .o_valid(b_valid),
    .o_halted(b_halted));

  instruction_fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) u_small (
    .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall), .i_halt(i_halt),
    .i_jump(i_jump), .i_jump_address(i_jump_address), .i_load_start(i_load_start),
    .i_load_valid(i_load_valid), .i_load_data(i_load_data), .i_load_last(i_load_last),
    .o_load_ready(s_ready), .o_load_done(s_done), .o_load_overflow(s_ovf),
    .o_instruction(s_instr), .o_pc(s_pc), .o_pc_plus4(s_pc4), .o_valid(s_valid),
    .o_halted(s_halted));

  typedef struct {
    logic        stall, halt, jump;
    logic [31:0] jaddr;
    logic [31:0] instr, pc, pc4;
    logic        valid;
  } vec_t;

  vec_t       tbl [17];
  logic [7:0] prog [32];
  int         n_vec = 0;
  int         n_bad = 0;

  function automatic logic [100:0] mk(input logic [31:0] instr, input logic [31:0] pc,
                                      input logic [31:0] pc4, input logic v, input logic r,
                                      input logic d, input logic h, input logic o);
    return {instr, pc, pc4, v, r, d, h, o};
  endfunction

  function automatic logic [100:0] snap_b();
    return {b_instr, b_pc, b_pc4, b_valid, b_ready, b_done, b_halted, b_ovf};
  endfunction

  function automatic logic [100:0] snap_s();
    return {s_instr, s_pc, s_pc4, s_valid, s_ready, s_done, s_halted, s_ovf};
  endfunction

  function automatic vec_t row(input logic st, input logic ht, input logic jp,
                               input logic [31:0] ja, input logic [31:0] ins,
                               input logic [31:0] pc, input logic [31:0] pc4,
                               input logic v);
    vec_t r;
    r.stall = st; r.halt = ht; r.jump = jp; r.jaddr = ja;
    r.instr = ins; r.pc = pc; r.pc4 = pc4; r.valid = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [100:0] act, input logic [100:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (instr,pc,pc4,valid,ready,done,halted,ovf)",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Start (or restart) a load, then stream prog[0..n-1]; optional noise on
  // stall/halt/jump which the loader must ignore.
  task automatic load_prog(input int n, input logic noise, input logic with_last);
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    check("load_entry", {96'h0, b_ready, b_valid, b_ovf, s_ready, s_ovf},
          {96'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    for (int k = 0; k < n; k++) begin
      i_load_valid   = 1'b1;
      i_load_data    = prog[k];
      i_load_last    = with_last && (k == n - 1);
      i_stall        = noise;
      i_halt         = noise;
      i_jump         = noise;
      i_jump_address = 32'h0000_0040;
      tick();
    end
    i_load_valid = 1'b0;
    i_load_last  = 1'b0;
    i_stall      = 1'b0;
    i_halt       = 1'b0;
    i_jump       = 1'b0;
  endtask

  initial begin
    i_reset = 1'b0; i_stall = 1'b0; i_halt = 1'b0; i_jump = 1'b0;
    i_jump_address = 32'h0; i_load_start = 1'b0; i_load_valid = 1'b0;
    i_load_data = 8'h0; i_load_last = 1'b0;

    // Reset state
    tick(); tick();
    check("reset_big", snap_b(), mk(NOP, 0, 0, 0, 0, 0, 0, 0));
    check("reset_small", snap_s(), mk(32'h0, 0, 0, 0, 0, 0, 0, 0));
    i_reset = 1'b1;

    // Load 00..0F; exactly fills the small RAM without wrapping
    for (int k = 0; k < 16; k++) prog[k] = 8'(k);
    load_prog(16, 1'b0, 1'b1);
    check("load_done_big", snap_b(), mk(NOP, 0, 0, 0, 0, 1, 0, 0));
    check("load_done_small", snap_s(), mk(32'h0, 0, 0, 0, 0, 1, 0, 0));

    // Run / jump flush / stall and halt precedence
    tbl[0]  = row(0, 0, 0, 32'h0,  32'h00010203, 32'h04, 32'h04, 1);
    tbl[1]  = row(0, 0, 0, 32'h0,  32'h04050607, 32'h08, 32'h08, 1);
    tbl[2]  = row(0, 0, 1, 32'h0E, NOP,          32'h0C, 32'h08, 0);
    tbl[3]  = row(0, 0, 0, 32'h0,  32'h0C0D0E0F, 32'h10, 32'h10, 1);
    tbl[4]  = row(0, 0, 1, 32'h0,  NOP,          32'h00, 32'h10, 0);
    tbl[5]  = row(0, 0, 0, 32'h0,  32'h00010203, 32'h04, 32'h04, 1);
    tbl[6]  = row(1, 0, 0, 32'h0,  32'h00010203, 32'h04, 32'h04, 1);
    tbl[7]  = row(1, 0, 0, 32'h0,  32'h00010203, 32'h04, 32'h04, 1);
    tbl[8]  = row(1, 0, 0, 32'h0,  32'h00010203, 32'h04, 32'h04, 1);
    tbl[9]  = row(1, 0, 1, 32'h08, NOP,          32'h08, 32'h04, 0);
    tbl[10] = row(0, 1, 1, 32'h0,  NOP,          32'h08, 32'h04, 0);
    tbl[11] = row(0, 1, 0, 32'h0,  NOP,          32'h08, 32'h04, 0);
    tbl[12] = row(0, 0, 0, 32'h0,  32'h08090A0B, 32'h0C, 32'h0C, 1);
    tbl[13] = row(1, 1, 0, 32'h0,  32'h08090A0B, 32'h0C, 32'h0C, 1);
    tbl[14] = row(0, 1, 1, 32'h0,  32'h08090A0B, 32'h0C, 32'h0C, 1);
    tbl[15] = row(0, 0, 1, 32'h03, NOP,          32'h00, 32'h0C, 0);
    tbl[16] = row(0, 0, 0, 32'h0,  32'h00010203, 32'h04, 32'h04, 1);
    for (int i = 0; i < 17; i++) begin
      i_stall = tbl[i].stall; i_halt = tbl[i].halt;
      i_jump = tbl[i].jump; i_jump_address = tbl[i].jaddr;
      tick();
      check($sformatf("run_vec%0d", i), snap_b(),
            mk(tbl[i].instr, tbl[i].pc, tbl[i].pc4, tbl[i].valid, 0, 0, 0, 0));
    end
    i_stall = 1'b0; i_halt = 1'b0; i_jump = 1'b0; i_jump_address = 32'h0;

    // Reset in the middle of a load keeps the bytes already written
    for (int k = 0; k < 5; k++) prog[k] = 8'(8'h50 + k);
    load_prog(5, 1'b0, 1'b0);
    check("mid_load", snap_b(), mk(NOP, 4, 4, 0, 1, 0, 0, 0));
    i_reset = 1'b0;
    tick();
    check("reset_mid_load", snap_b(), mk(NOP, 0, 0, 0, 0, 0, 0, 0));
    i_reset = 1'b1;
    tick();
    check("after_reset_w0", snap_b(), mk(32'h50515253, 4, 4, 1, 0, 0, 0, 0));
    tick();
    check("after_reset_w1", snap_b(), mk(32'h54050607, 8, 8, 1, 0, 0, 0, 0));

    // Overflow: 18 bytes into the 16-byte RAM, control noise ignored while loading
    for (int k = 0; k < 18; k++) prog[k] = 8'(8'h20 + k);
    load_prog(18, 1'b1, 1'b1);
    check("ovf_done_big", snap_b(), mk(NOP, 0, 8, 0, 0, 1, 0, 0));
    check("ovf_done_small", snap_s(), mk(32'h0, 0, 8, 0, 0, 1, 0, 1));
    tick();
    check("ovf_fetch_big", snap_b(), mk(32'h20212223, 4, 4, 1, 0, 0, 0, 0));
    check("ovf_fetch_small", snap_s(), mk(32'h30312223, 4, 4, 1, 0, 0, 0, 1));

    // Restart inside LOAD rewinds the pointer and clears overflow
    for (int k = 0; k < 17; k++) prog[k] = 8'(8'h40 + k);
    load_prog(17, 1'b0, 1'b0);
    check("wrap_in_load_small", snap_s(), mk(32'h0, 4, 4, 0, 1, 0, 0, 1));
    prog[0] = 8'hA0; prog[1] = 8'hA1;
    load_prog(2, 1'b0, 1'b1);
    check("restart_done_small", snap_s(), mk(32'h0, 0, 4, 0, 0, 1, 0, 0));
    tick();
    check("restart_fetch_small", snap_s(), mk(32'hA0A14243, 4, 4, 1, 0, 0, 0, 0));
    check("restart_fetch_big", snap_b(), mk(32'hA0A14243, 4, 4, 1, 0, 0, 0, 0));

    // All-ones word at address 8
    for (int k = 0; k < 16; k++) prog[k] = (k >= 8 && k < 12) ? 8'hFF : 8'(k);
    load_prog(16, 1'b0, 1'b1);
    check("halt_prog_done", {100'h0, b_done}, {100'h0, 1'b1});
    tick();
    check("halt_w0", snap_b(), mk(32'h00010203, 4, 4, 1, 0, 0, 0, 0));
    tick();
    check("halt_w1", snap_b(), mk(32'h04050607, 8, 8, 1, 0, 0, 0, 0));
    tick();
    check("halt_word", snap_b(), mk(32'hFFFFFFFF, 32'h0C, 32'h0C, 1, 0, 0, 0, 0));
`ifdef IF_HALT_DETECT_EN
    tick();
    check("halted_enter", snap_b(), mk(NOP, 32'h0C, 32'h0C, 0, 0, 0, 1, 0));
    i_jump = 1'b1; i_stall = 1'b1; i_jump_address = 32'h0;
    tick();
    check("halted_jump_ignored", snap_b(), mk(NOP, 32'h0C, 32'h0C, 0, 0, 0, 1, 0));
    i_jump = 1'b0; i_stall = 1'b0;
    tick();
    check("halted_frozen", snap_b(), mk(NOP, 32'h0C, 32'h0C, 0, 0, 0, 1, 0));
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    check("halted_to_load", snap_b(), mk(NOP, 32'h0C, 32'h0C, 0, 1, 0, 0, 0));
`else
    tick();
    check("allones_ordinary", snap_b(), mk(32'h0C0D0E0F, 32'h10, 32'h10, 1, 0, 0, 0, 0));
    i_jump = 1'b1; i_jump_address = 32'h0;
    tick();
    i_jump = 1'b0;
    check("allones_jump", snap_b(), mk(NOP, 32'h0, 32'h10, 0, 0, 0, 0, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Parametrised next-generation IF stage.
- Holds a byte-addressable instruction RAM with a configurable PC reset value and depth.
- Supports jump redirect with a one-bubble flush, stall/halt freeze, and a streaming byte loader FSM with valid/ready handshake.
- Sits between the program loader (debug/UART side) and the IF/ID pipeline register consumed by decode.

Parameters:
- DATA_WIDTH, 32, instruction width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, byte address bits; memory depth is 2^ADDR_WIDTH bytes.
- RESET_PC, 0, PC value after reset and after a completed load; word-aligned.
- NOP_INSTR, 32'h0, value driven into the IF/ID latch on reset or flush.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_stall  in  1  hazard stall; holds PC and latch.
- i_halt  in  1  level freeze; holds PC and latch.
- i_jump  in  1  redirect request.
- i_jump_address  in  32  redirect target.
- i_load_start  in  1  pulse; enter LOAD state.
- i_load_valid  in  1  loader byte valid.
- i_load_data  in  8  loader byte.
- i_load_last  in  1  qualifies final byte.
- o_load_ready  out  1  high while in LOAD.
- o_load_done  out  1  one-cycle pulse on LOAD exit.
- o_load_overflow  out  1  sticky; write pointer wrapped during load.
- o_instruction  out  DATA_WIDTH  IF/ID instruction latch.
- o_pc  out  32  current fetch PC.
- o_pc_plus4  out  32  registered PC+4 of latched instruction.
- o_valid  out  1  latch holds a real instruction.
- o_halted  out  1  FSM in HALTED state.

Behaviour:
- **Reset** (i_reset==0 at posedge):
  - PC=RESET_PC, o_instruction=NOP_INSTR, o_pc_plus4=0.
  - o_valid=0, o_load_ready=0, o_load_done=0, o_load_overflow=0, o_halted=0.
  - State=RUN. Memory contents are not cleared.
- **Memory**:
  - Asynchronous read of DATA_WIDTH/8 consecutive bytes, big-endian (byte at lowest address lands in MSB).
  - Read base is PC[ADDR_WIDTH-1:0] with the low 2 bits forced to 0; byte addresses wrap modulo depth.
  - Write is synchronous, one byte per cycle.
- **FSM states**: RUN, LOAD, HALTED (HALTED exists only with the optional feature).
- **RUN, priority order high to low**: i_load_start > i_halt > i_jump > i_stall > normal.
  - i_load_start: go to LOAD next cycle; latch <= NOP_INSTR; o_valid <= 0.
  - i_halt: PC, latch, o_valid and o_pc_plus4 all hold.
  - i_jump: PC <= {i_jump_address[31:2],2'b00}; latch <= NOP_INSTR; o_valid <= 0. This flushes exactly one bubble, and the jump overrides i_stall.
  - i_stall: PC, latch, o_valid and o_pc_plus4 hold.
  - Normal: latch <= mem[PC]; o_pc_plus4 <= PC+4; PC <= PC+4 (32-bit wrap); o_valid <= 1.
- **LOAD**:
  - On entry: write pointer=0, o_load_overflow cleared, o_load_ready=1, PC held, o_valid=0.
  - i_stall, i_halt and i_jump are ignored.
  - Byte accepted when i_load_valid && o_load_ready: mem[ptr] <= i_load_data, ptr <= ptr+1.
  - If ptr was 2^ADDR_WIDTH-1 on a non-last byte, ptr wraps to 0 and o_load_overflow is set.
  - Accepted byte with i_load_last=1: next cycle state=RUN, PC=RESET_PC, latch=NOP_INSTR, o_load_ready=0, o_load_done=1 for one cycle.
  - i_load_start while already in LOAD restarts the load (ptr=0, overflow cleared).
- **Reset mid-load**: returns to RUN. Bytes already written remain; the partial program is not invalidated.
- **Latency**: the instruction at PC appears on o_instruction one cycle after PC is presented.

Optional Feature:
- Macro: IF_HALT_DETECT_EN.
- **Defined**:
  - In RUN, when a normal fetch reads the all-ones word (32'hFFFFFFFF, the HALT opcode), that word is latched with o_valid=1.
  - Next cycle the state becomes HALTED: o_halted=1, PC frozen at the HALT address+4, latch <= NOP_INSTR, o_valid=0.
  - HALTED is left only by reset (to RUN) or by i_load_start (to LOAD).
- **Not defined**: the all-ones word is an ordinary instruction, the HALTED state is absent, and o_halted is tied to 0.

Test Plan:
1. **Load and run**: reset, load 16 bytes 00..0F with last on byte 16 → o_load_done pulse; then o_instruction sequence 32'h00010203, 32'h04050607, ...; o_pc_plus4 = 4, 8, ...; o_valid=1.
2. **Jump flush**: in RUN at PC=8, assert i_jump with address 32'h0000000E for 1 cycle → PC=0x0C; next latch is NOP_INSTR with o_valid=0; following cycle latches mem[0x0C].
3. **Stall/halt precedence**: i_stall=1 for 3 cycles → PC and latch constant; i_stall=1 together with i_jump=1 → jump taken; i_halt=1 together with i_jump=1 → everything holds.
4. **Overflow**: ADDR_WIDTH=4, stream 18 bytes with last on byte 18 → o_load_overflow=1; bytes 17 and 18 land at addresses 0 and 1.
5. **Reset mid-load**: after 5 bytes, pull i_reset low → o_load_ready=0, PC=RESET_PC, state RUN, and the 5 written bytes are readable.
6. **HALT detect** (IF_HALT_DETECT_EN): program word 2 = 32'hFFFFFFFF → after fetching it, o_halted=1, o_valid=0, PC=0x0C stays frozen; i_load_start exits to LOAD.
